// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_period_meter_pkg;

  localparam int unsigned COUNTER_W_DEFAULT = 26;
  localparam int unsigned STATE_W           = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_e;

endpackage : clk_period_meter_pkg

// File: rtl/clk_period_meter_if.sv
// Control and result bundle of the clock period meter.
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned COUNTER_W = COUNTER_W_DEFAULT
) ();

  logic                 en;
  logic                 clk_meas;
  logic [COUNTER_W-1:0] period;
  logic [COUNTER_W-1:0] high_time;
  logic                 valid;
  logic                 timeout;
  logic                 busy;

  modport master (
    output en,
    output clk_meas,
    input  period,
    input  high_time,
    input  valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  en,
    input  clk_meas,
    output period,
    output high_time,
    output valid,
    output timeout,
    output busy
  );

endinterface : clk_period_meter_if

// File: rtl/clk_period_meter_sync_edge_det.sv
// Two-flop synchronizer plus one delay flop; flags single-cycle rise/fall
// of the synchronized input.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // sync_q and dly_q can only differ one way at a time, so these never overlap
  assign rise_c = sync_q & ~dly_q;
  assign fall_c = ~sync_q & dly_q;

endmodule : sync_edge_det

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles,
// with a sticky timeout when the input stops toggling.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned COUNTER_W = COUNTER_W_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  clk_period_meter_if.slave mif
);

  localparam logic [COUNTER_W-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_W-1:0] CNT_ZERO = '0;
  localparam logic [COUNTER_W-1:0] CNT_ONE  = COUNTER_W'(1);

  logic rise;
  logic fall;

  state_e               state_q,     state_d;
  logic [COUNTER_W-1:0] cnt_q,       cnt_d;
  logic [COUNTER_W-1:0] ht_next_q,   ht_next_d;
  logic [COUNTER_W-1:0] period_q,    period_d;
  logic [COUNTER_W-1:0] high_time_q, high_time_d;
  logic                 valid_q,     valid_d;
  logic                 timeout_q,   timeout_d;
  logic                 busy_q,      busy_d;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst      (rst),
    .async_in (mif.clk_meas),
    .rise_c   (rise),
    .fall_c   (fall)
  );

  // Next-state, counter and result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ht_next_d   = ht_next_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!mif.en) begin
      state_d   = ST_IDLE;
      cnt_d     = CNT_ZERO;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = CNT_ZERO;
          state_d = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          cnt_d = CNT_ZERO;
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (fall) begin
            ht_next_d = cnt_q;
          end
          // A rise on the saturation cycle still counts as a measurement
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = ht_next_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = CNT_ZERO;
            state_d   = ST_WAIT_RISE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      ht_next_q   <= CNT_ZERO;
      period_q    <= CNT_ZERO;
      high_time_q <= CNT_ZERO;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ht_next_q   <= ht_next_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign mif.period    = period_q;
  assign mif.high_time = high_time_q;
  assign mif.valid     = valid_q;
  assign mif.timeout   = timeout_q;
  assign mif.busy      = busy_q;

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: expected measurements are queued as
// the input wave is driven and checked whenever valid pulses.
module tb_clk_period_meter;

  localparam int unsigned W = 6;

  typedef struct {
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    int           gap;
  } exp_t;

  logic clk;
  logic rst;

  int   n_tests;
  int   n_fail;
  int   cyc;
  int   last_valid_cyc;
  exp_t exp_q[$];
  exp_t mon_e;

  clk_period_meter_if #(.COUNTER_W(W)) mif ();

  clk_period_meter #(.COUNTER_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst && mif.valid) begin
      n_tests = n_tests + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_valid: got valid with period=%0d high_time=%0d, required no valid",
                 mif.period, mif.high_time);
      end else begin
        mon_e = exp_q.pop_front();
        n_tests = n_tests + 3;
        if (mif.period !== mon_e.period) begin
          n_fail = n_fail + 1;
          $display("FAIL period: got %0d, required %0d", mif.period, mon_e.period);
        end
        if (mif.high_time !== mon_e.high_time) begin
          n_fail = n_fail + 1;
          $display("FAIL high_time: got %0d, required %0d", mif.high_time, mon_e.high_time);
        end
        if (mif.timeout !== 1'b0) begin
          n_fail = n_fail + 1;
          $display("FAIL timeout_at_valid: got %b, required 0", mif.timeout);
        end
        if (mon_e.gap != 0) begin
          n_tests = n_tests + 1;
          if ((cyc - last_valid_cyc) != mon_e.gap) begin
            n_fail = n_fail + 1;
            $display("FAIL valid_gap: got %0d cycles, required %0d", cyc - last_valid_cyc, mon_e.gap);
          end
        end
      end
      last_valid_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart_idle();
    mif.en       = 1'b0;
    mif.clk_meas = 1'b0;
    tick(3);
    mif.en = 1'b1;
    tick(3);
  endtask

  // n+1 rises of an h-high / l-low wave; every rise after the first yields one measurement
  task automatic drive_wave(input int h, input int l, input int n);
    exp_t e;
    for (int k = 0; k <= n; k++) begin
      mif.clk_meas = 1'b1;
      if (k >= 1) begin
        e.period    = W'(h + l);
        e.high_time = W'(h);
        e.gap       = (k >= 2) ? (h + l) : 0;
        exp_q.push_back(e);
      end
      tick(h);
      mif.clk_meas = 1'b0;
      tick(l);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    mif.en       = 1'b0;
    mif.clk_meas = 1'b0;
    tick(2);
    n_tests = n_tests + 5;
    if (mif.period !== '0)    begin n_fail++; $display("FAIL reset_period: got %0d, required 0", mif.period); end
    if (mif.high_time !== '0) begin n_fail++; $display("FAIL reset_high_time: got %0d, required 0", mif.high_time); end
    if (mif.valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b, required 0", mif.valid); end
    if (mif.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b, required 0", mif.timeout); end
    if (mif.busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b, required 0", mif.busy); end
    rst = 1'b1;
    tick(2);
    n_tests = n_tests + 1;
    if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", mif.busy); end
  endtask

  task automatic test_div8();
    restart_idle();
    n_tests = n_tests + 1;
    if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL div8_busy: got %b, required 1", mif.busy); end
    drive_wave(4, 4, 5);
    wait_drain(40);
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL div8_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_duty25();
    restart_idle();
    drive_wave(5, 15, 3);
    wait_drain(40);
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL duty25_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_min_phase();
    restart_idle();
    drive_wave(2, 2, 6);
    wait_drain(40);
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL min_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_latency();
    exp_t e;
    logic exp_v;
    restart_idle();
    mif.clk_meas = 1'b1;
    tick(4);
    mif.clk_meas = 1'b0;
    tick(4);
    e.period = W'(8); e.high_time = W'(4); e.gap = 0;
    exp_q.push_back(e);
    mif.clk_meas = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exp_v = (i == 4);
      n_tests = n_tests + 1;
      if (mif.valid !== exp_v) begin
        n_fail++;
        $display("FAIL latency_valid_%0d: got %b, required %b", i, mif.valid, exp_v);
      end
    end
    @(posedge clk);
    #1;
    mif.clk_meas = 1'b0;
    tick(4);
    wait_drain(20);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   c0;
    int   seen;
    restart_idle();
    mif.clk_meas = 1'b1;
    tick(5);
    mif.clk_meas = 1'b0;
    tick(5);
    e.period = W'(10); e.high_time = W'(5); e.gap = 0;
    exp_q.push_back(e);
    mif.clk_meas = 1'b1;
    c0 = cyc;
    tick(5);
    mif.clk_meas = 1'b0;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (mif.timeout === 1'b1) begin
        seen = cyc - c0;
        break;
      end
    end
    n_tests = n_tests + 5;
    if (seen != 66) begin n_fail++; $display("FAIL timeout_cycle: got %0d cycles after rise, required 66", seen); end
    if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy: got %b, required 1", mif.busy); end
    if (mif.period !== W'(10)) begin n_fail++; $display("FAIL timeout_period_hold: got %0d, required 10", mif.period); end
    if (mif.high_time !== W'(5)) begin n_fail++; $display("FAIL timeout_ht_hold: got %0d, required 5", mif.high_time); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL timeout_drain: got %0d pending, required 0", exp_q.size()); end
    @(posedge clk);
    #1;
    tick(5);
    n_tests = n_tests + 1;
    if (mif.timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b, required 1", mif.timeout); end
    drive_wave(5, 5, 1);
    wait_drain(20);
    n_tests = n_tests + 2;
    if (mif.timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b, required 0", mif.timeout); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL restart_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_en_drop();
    restart_idle();
    drive_wave(4, 4, 2);
    wait_drain(20);
    mif.clk_meas = 1'b1;
    tick(2);
    mif.en = 1'b0;
    tick(1);
    n_tests = n_tests + 5;
    if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL endrop_busy: got %b, required 0", mif.busy); end
    if (mif.valid !== 1'b0) begin n_fail++; $display("FAIL endrop_valid: got %b, required 0", mif.valid); end
    if (mif.timeout !== 1'b0) begin n_fail++; $display("FAIL endrop_timeout: got %b, required 0", mif.timeout); end
    if (mif.period !== W'(8)) begin n_fail++; $display("FAIL endrop_period_hold: got %0d, required 8", mif.period); end
    if (mif.high_time !== W'(4)) begin n_fail++; $display("FAIL endrop_ht_hold: got %0d, required 4", mif.high_time); end
    tick(2);
    mif.clk_meas = 1'b0;
    tick(4);
    mif.clk_meas = 1'b1;
    tick(4);
    mif.clk_meas = 1'b0;
    tick(4);
    mif.en = 1'b1;
    tick(2);
    drive_wave(4, 4, 1);
    wait_drain(20);
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL enrestart_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    restart_idle();
    drive_wave(4, 4, 1);
    wait_drain(20);
    mif.clk_meas = 1'b1;
    tick(3);
    #3;
    rst = 1'b0;
    #1;
    n_tests = n_tests + 5;
    if (mif.period !== '0)    begin n_fail++; $display("FAIL rstmid_period: got %0d, required 0", mif.period); end
    if (mif.high_time !== '0) begin n_fail++; $display("FAIL rstmid_high_time: got %0d, required 0", mif.high_time); end
    if (mif.valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", mif.valid); end
    if (mif.timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout: got %b, required 0", mif.timeout); end
    if (mif.busy !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", mif.busy); end
    mif.clk_meas = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    drive_wave(4, 4, 2);
    wait_drain(20);
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    cyc            = 0;
    last_valid_cyc = 0;
    rst            = 1'b0;
    mif.en         = 1'b0;
    mif.clk_meas   = 1'b0;
    test_reset();
    test_div8();
    test_duty25();
    test_min_phase();
    test_latency();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_clk_period_meter

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous clock-like input (such as the output of a divider chain) in cycles of the system clock. Produces a one-cycle `valid` pulse with each new measurement. Flags a timeout when the input stops toggling. It is the receive-side check for generated clocks: it verifies a divider setting in hardware, or decodes a clock-encoded rate from an external source.

## Interface
- `COUNTER_W`, default 26: width of the internal counter and of both result ports.
- `clk` input, 1: system clock; all logic is on its rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `en` input, 1: measurement enable; low forces IDLE.
- `clk_meas` input, 1: signal under measurement, asynchronous to `clk`.
- `period` output, COUNTER_W: last measured rise-to-rise distance, in `clk` cycles.
- `high_time` output, COUNTER_W: last measured rise-to-fall distance, in `clk` cycles.
- `valid` output, 1: one-cycle pulse when `period` and `high_time` update.
- `timeout` output, 1: sticky flag; no rising edge arrived within 2^COUNTER_W−1 cycles.
- `busy` output, 1: high in WAIT_RISE and MEASURE.

## Operation
- Input path: `clk_meas` passes through a 2-flop synchronizer, then a registered delay copy.
  - `rise` = sync & ~sync_d.
  - `fall` = ~sync & sync_d.
  - `rise` and `fall` are mutually exclusive by construction.
- Counter `cnt`, COUNTER_W bits, saturating.
- FSM states: IDLE, WAIT_RISE, MEASURE.
- IDLE:
  - `cnt` = 0.
  - `en` = 1 moves to WAIT_RISE next cycle.
- WAIT_RISE:
  - On `rise`: `cnt` <= 1, go to MEASURE.
  - No output update on this first edge.
- MEASURE, `cnt` increments by 1 every cycle:
  - On `fall`: `high_time_next` <= `cnt`. This is an internal holding register; the `high_time` port does not change yet.
  - On `rise`:
    - `period` <= `cnt`.
    - `high_time` <= `high_time_next`.
    - `valid` <= 1 and `timeout` <= 0.
    - `cnt` <= 1; stay in MEASURE, so measurement is continuous.
  - Captures use the value of `cnt` before the increment.
  - If `cnt` = 2^COUNTER_W−1 and there is no `rise`:
    - `timeout` <= 1.
    - go to WAIT_RISE.
    - `period` and `high_time` hold.
- `en` = 0 in any state:
  - go to IDLE next cycle.
  - `valid` stays 0; `timeout` clears.
  - `period` and `high_time` hold their last values.
- Arithmetic: plain unsigned; the counter never wraps.
- Validity range: input high and low phases must each be ≥2 `clk` cycles. Shorter phases give unspecified results but must not hang the FSM.

## Timing
- Reset values:
  - `period` = 0, `high_time` = 0.
  - `valid` = 0, `timeout` = 0, `busy` = 0.
  - FSM in IDLE, `cnt` = 0, synchronizer flops = 0.
- Latency: `valid` is high during the 3rd `clk` cycle after the first `clk` edge that samples `clk_meas` high (2 synchronizer edges + 1 capture edge).
- `valid` is exactly one cycle wide, with at most one pulse per input period.
- Throughput: one measurement per input period, with no dead cycles between measurements.
- Reset asserted mid-measurement: everything returns to reset values immediately. The first edge after reset release starts a fresh WAIT_RISE.
- `timeout` rises in the same cycle the FSM leaves MEASURE.
- `rise` in the same cycle as counter saturation: the `rise` wins, giving `period` = 2^COUNTER_W−1 with `valid` and no timeout.

## Structure
- State encoding goes in the shared utility package as a 2-bit enum/localparam set (IDLE=0, WAIT_RISE=1, MEASURE=2).
- One sub-module, `sync_edge_det`: 2-flop synchronizer, delay flop, `rise`/`fall` outputs, reset to 0 via `rst`.
- Counter, FSM and output registers live in the top module.

## Test plan
- Divide-by-8 square wave (4 high / 4 low), `en` = 1:
  - No `valid` on the first edge.
  - From the second rise on, `valid` pulses every 8 cycles with `period` = 8 and `high_time` = 4.
- 25% duty, period 20 (5 high / 15 low): `period` = 20, `high_time` = 5 on every `valid`.
- Minimum input (2 high / 2 low): `period` = 4, `high_time` = 2, `valid` every 4 cycles.
- With COUNTER_W = 6, stop toggling after one valid measurement:
  - 63 cycles after the last rise, `timeout` = 1, `busy` stays 1, outputs hold.
  - Restart toggling at period 10: the next-but-one rise gives `valid` with `period` = 10 and `timeout` = 0.
- Drop `en` mid-period: IDLE next cycle, no `valid`, `busy` = 0, `timeout` = 0, `period` holds. Re-raise `en`: a full WAIT_RISE sequence occurs before the next `valid`.
- Assert `rst` (low) mid-measurement: all outputs 0 asynchronously. After release, the first `valid` arrives only after two rising edges.
